bcd_seq_adder: RTL and testbench

BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_add.sv | 32 +++
 rtl/bcd_seq_adder.sv | 142 ++++++++++++++
 tb/tb_bcd_seq_adder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: constants and types shared by the sequential BCD adder.
//   DIGIT_W  - bits per packed BCD digit
//   BCD_MAX  - largest legal decimal digit
//   BCD_CORR - correction added to a digit sum that exceeds BCD_MAX
//   state_t  - controller states (IDLE, ADD, DONE)
//   digit_bad() - true when a 4-bit digit is not a legal BCD digit
package bcd_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder.
//   a, b : 4-bit BCD digits
//   cin  : decimal carry in
//   s    : 4-bit BCD result digit
//   cout : decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [DIGIT_W:0] raw;
  logic [DIGIT_W:0] corr;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    corr = raw + (DIGIT_W + 1)'(BCD_CORR);
    if (raw > (DIGIT_W + 1)'(BCD_MAX)) begin
      // Adding 6 skips the six unused codes; the mod-16 wrap drops bit 4.
      s    = corr[DIGIT_W-1:0];
      cout = 1'b1;
    end else begin
      s    = raw[DIGIT_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: adds two packed BCD operands one digit per cycle using a
// single time-shared bcd_digit_add.
//   clock     : sole clock, rising edge
//   reset     : synchronous, active-high
//   start     : request; accepted only in IDLE (operands sampled then)
//   a, b      : packed BCD operands, digit 0 in bits [3:0]
//   cin       : decimal carry into digit 0
//   busy      : high only in ADD
//   done      : one-cycle pulse (DONE state) marking sum/cout/err valid
//   sum, cout : BCD result and carry out of the top digit
//   err       : last accepted operand pair contained a digit > 9
//   state_dbg : current controller state
//
// Handshake: start is a level request with no ready; it is taken on the
// rising edge where the controller is in IDLE and ignored otherwise.
// Results are valid while done is high and are held until the next
// accepted start.
module bcd_seq_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      err,
  output state_t                    state_dbg
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               carry_q, cout_q, err_q;
  logic [IDX_W-1:0]   idx_q;
  logic               in_bad;
  logic               last_digit;
  logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
  logic               c_dig;

  assign last_digit = (idx_q == LAST_IDX);

  // Any illegal digit in the incoming operands routes straight to DONE.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_bad(a[i*DIGIT_W +: DIGIT_W]) || digit_bad(b[i*DIGIT_W +: DIGIT_W]))
        in_bad = 1'b1;
    end
  end

  // Select the current digit of each registered operand.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[i*DIGIT_W +: DIGIT_W];
        b_dig = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  bcd_digit_add u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry_q),
    .s    (s_dig),
    .cout (c_dig)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = in_bad ? DONE : ADD;
      ADD:     if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            err_q   <= in_bad;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) sum_q[i*DIGIT_W +: DIGIT_W] <= s_dig;
          end
          carry_q <= c_dig;
          if (last_digit) begin
            cout_q <= c_dig;
            idx_q  <= '0;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb_bcd_seq_adder: directed table, hand-written corner sequences and
// randomized operations for bcd_seq_adder (DIGITS=4), checked against a
// decimal-arithmetic reference model.
module tb_bcd_seq_adder;
  import bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;
  state_t       state_dbg;

  always #5 clock = ~clock;

  bcd_seq_adder #(.DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .err       (err),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {err, cout, sum}.
  logic [W+1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic has_bad(input logic [W-1:0] x);
    for (int i = 0; i < DIGITS; i++)
      if (x[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int bcd_val(input logic [W-1:0] x);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int total;
    if (has_bad(x) || has_bad(y)) return {1'b1, 1'b0, {W{1'b0}}};
    total = bcd_val(x) + bcd_val(y) + int'(c);
    return {1'b0, (total >= 10000), to_bcd(total % 10000)};
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for done, counting cycles since the acceptance edge.
  task automatic wait_done(output int lat, output int busy_cyc, output int overlap);
    lat = 1; busy_cyc = 0; overlap = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      step();
      lat++;
    end
    if (busy && done) overlap = 1;
  endtask

  task automatic compare_result(input string name);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_sum"},  32'(sum),  32'(e[W-1:0]));
    check({name, "_cout"}, 32'(cout), 32'(e[W]));
    check({name, "_err"},  32'(err),  32'(e[W+1]));
  endtask

  // Full operation: accept, scramble operands, wait, compare, check hold.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc);
    int lat, busy_cyc, overlap;
    logic bad;
    logic [W-1:0] held;
    bad = has_bad(ta) || has_bad(tb_v);
    exp_q.push_back(model(ta, tb_v, tc));
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    step();
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    wait_done(lat, busy_cyc, overlap);
    check({name, "_done"},    32'(done), 32'd1);
    check({name, "_latency"}, 32'(lat), bad ? 32'd1 : 32'(DIGITS + 1));
    check({name, "_busycyc"}, 32'(busy_cyc), bad ? 32'd0 : 32'(DIGITS));
    check({name, "_overlap"}, 32'(overlap), 32'd0);
    compare_result(name);
    held = sum;
    step();
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_sum_hold"},   32'(sum),  32'(held));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, busy_cyc, overlap;

    vecs[0] = '{"basic",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"ripple",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"maxin",   16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{"baddig",  16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{"cin_one", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{"badb",    16'h0001, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_sum",   32'(sum),       32'd0);
    check("rst_cout",  32'(cout),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_cout, vecs[i].exp_sum});
      start = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      step();
      start = 1'b0;
      wait_done(lat, busy_cyc, overlap);
      check({vecs[i].name, "_done"},    32'(done), 32'd1);
      check({vecs[i].name, "_latency"}, 32'(lat), vecs[i].exp_err ? 32'd1 : 32'd5);
      check({vecs[i].name, "_busycyc"}, 32'(busy_cyc), vecs[i].exp_err ? 32'd0 : 32'd4);
      compare_result(vecs[i].name);
      step();
    end

    // Reset during the second ADD cycle discards the partial result.
    start = 1'b1; a = 16'h4321; b = 16'h1111; cin = 1'b0;
    step();
    start = 1'b0;
    step();
    check("midrst_in_add", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum",  32'(sum),  32'd0);
    run_op("after_rst", 16'h0005, 16'h0005, 1'b0);

    // Start held high across two operations.
    exp_q.push_back(model(16'h1234, 16'h5678, 1'b0));
    start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
    step();
    check("held_sum_cleared", 32'(sum), 32'd0);
    a = 16'h1111; b = 16'h2222;
    wait_done(lat, busy_cyc, overlap);
    check("held1_latency", 32'(lat), 32'd5);
    compare_result("held1");
    step();
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_done", 32'(done), 32'd0);
    check("held_idle_sum",  32'(sum),  32'h6912);
    step();
    check("held2_accepted", 32'(busy), 32'd1);
    start = 1'b0;
    exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
    wait_done(lat, busy_cyc, overlap);
    check("held2_latency", 32'(lat), 32'd5);
    compare_result("held2");
    step();

    // Randomized operations against the decimal model.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      for (int d = 0; d < DIGITS; d++) begin
        ra[d*4 +: 4] = 4'($urandom_range(0, 9));
        rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(10, 15));
      run_op("rand", ra, rb, 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
